eth_fcs_append: RTL

Parametrised Ethernet transmit framer stage that takes a byte stream qualified by a data-valid strobe and emits the same bytes with three additions. It zero-pads short frames up to a configurable minimum length, appends the IEEE 802.3 CRC-32 FCS (least significant byte first), and enforces a configurable inter-frame gap. It sits between the MAC payload source and the RGMII transmit serializer. An input-side ready/drop handshake lets upstream logic know when a new frame may start.

---
 rtl/eth_fcs_append.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_fcs_append.sv
// Ethernet transmit framer stage: zero-pads short frames, appends the
// reflected CRC-32 FCS (LSB first) and enforces an inter-frame gap.
module eth_fcs_append #(
    parameter int unsigned MIN_FRAME  = 60,
    parameter int unsigned APPEND_FCS = 1,
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dv,
    input  logic [7:0] i_data_in,
    output logic       o_ready,
    output logic       o_drop,
    output logic       o_dv,
    output logic [7:0] o_data_out,
    output logic       o_busy
);

    localparam int unsigned GAP_W     = 9;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [CNT_W:0] MIN_EXT = (CNT_W+1)'(MIN_FRAME);
    localparam logic [GAP_W-1:0] GAP_NOW  = GAP_W'(IFG_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LATE = GAP_W'(IFG_CYCLES + 1);
    localparam bit HAS_FCS = (APPEND_FCS != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_GAP
    } state_t;

    state_t           state;
    logic [31:0]      crc;
    logic [CNT_W-1:0] count;
    logic [1:0]       fcs_idx;
    logic [GAP_W-1:0] gap_left;

    logic [31:0]      crc_data_c;
    logic [31:0]      crc_pad_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             short_c;
    logic             pad_last_c;

    // One byte of the reflected CRC-32, bit 0 of the data first
    function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // True when v is below MIN_FRAME (written as v+1 <= MIN to stay non-constant at MIN=0)
    function automatic logic below_min(input logic [CNT_W-1:0] v);
        return (({1'b0, v} + (CNT_W+1)'(1)) <= MIN_EXT);
    endfunction

    // Complemented CRC byte selected by the FCS byte index
    function automatic logic [7:0] fcs_sel(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] f;
        f = ~c;
        case (idx)
            2'd0:    return f[7:0];
            2'd1:    return f[15:8];
            2'd2:    return f[23:16];
            default: return f[31:24];
        endcase
    endfunction

    // Next CRC for a data byte or a pad byte, plus saturating count helpers
    always_comb begin
        crc_data_c = crc_next((state == ST_IDLE) ? CRC_INIT : crc, i_data_in);
        crc_pad_c  = crc_next(crc, 8'h00);
        cnt_inc_c  = (count == '1) ? count : count + CNT_W'(1);
        short_c    = below_min(count);
        pad_last_c = !below_min(cnt_inc_c);
    end

    // Framer state machine with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            crc        <= CRC_INIT;
            count      <= '0;
            fcs_idx    <= '0;
            gap_left   <= '0;
            o_ready    <= 1'b0;
            o_drop     <= 1'b0;
            o_dv       <= 1'b0;
            o_data_out <= 8'h00;
            o_busy     <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_ready    <= 1'b1;
                    o_dv       <= 1'b0;
                    o_data_out <= 8'h00;
                    crc        <= CRC_INIT;
                    count      <= '0;
                    if (i_dv) begin
                        state      <= ST_DATA;
                        crc        <= crc_data_c;
                        count      <= CNT_W'(1);
                        o_dv       <= 1'b1;
                        o_data_out <= i_data_in;
                        o_busy     <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (i_dv) begin
                        o_ready    <= 1'b1;
                        o_dv       <= 1'b1;
                        o_data_out <= i_data_in;
                        crc        <= crc_data_c;
                        count      <= cnt_inc_c;
                    end else if (short_c) begin
                        // first pad byte follows the last data byte directly
                        o_ready    <= 1'b0;
                        o_dv       <= 1'b1;
                        o_data_out <= 8'h00;
                        crc        <= crc_pad_c;
                        count      <= cnt_inc_c;
                        if (!pad_last_c) begin
                            state <= ST_PAD;
                        end else if (HAS_FCS) begin
                            state   <= ST_FCS;
                            fcs_idx <= 2'd0;
                        end else begin
                            state    <= ST_GAP;
                            gap_left <= GAP_LATE;
                        end
                    end else if (HAS_FCS) begin
                        // first FCS byte follows the last data byte directly
                        o_ready    <= 1'b0;
                        o_dv       <= 1'b1;
                        o_data_out <= fcs_sel(crc, 2'd0);
                        fcs_idx    <= 2'd1;
                        state      <= ST_FCS;
                    end else begin
                        // o_dv falls on this edge, so the gap counts from here
                        o_dv       <= 1'b0;
                        o_data_out <= 8'h00;
                        if (IFG_CYCLES == 0) begin
                            state   <= ST_IDLE;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            state    <= ST_GAP;
                            o_ready  <= 1'b0;
                            gap_left <= GAP_NOW;
                        end
                    end
                end
                ST_PAD: begin
                    o_drop     <= i_dv;
                    o_ready    <= 1'b0;
                    o_dv       <= 1'b1;
                    o_data_out <= 8'h00;
                    crc        <= crc_pad_c;
                    count      <= cnt_inc_c;
                    if (pad_last_c) begin
                        if (HAS_FCS) begin
                            state   <= ST_FCS;
                            fcs_idx <= 2'd0;
                        end else begin
                            state    <= ST_GAP;
                            gap_left <= GAP_LATE;
                        end
                    end
                end
                ST_FCS: begin
                    o_drop     <= i_dv;
                    o_ready    <= 1'b0;
                    o_dv       <= 1'b1;
                    o_data_out <= fcs_sel(crc, fcs_idx);
                    fcs_idx    <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        // last byte still on the wire for one cycle, so one extra gap tick
                        state    <= ST_GAP;
                        gap_left <= GAP_LATE;
                    end
                end
                ST_GAP: begin
                    o_drop     <= i_dv;
                    o_dv       <= 1'b0;
                    o_data_out <= 8'h00;
                    o_ready    <= 1'b0;
                    if (gap_left <= GAP_W'(1)) begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        gap_left <= gap_left - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
